// File: rtl/crypto_job_arbiter_if.sv
// Requester/core bus for crypto_job_arbiter. The master modport is the environment
// (requesters and crypto core); the slave modport is the arbiter.
interface crypto_job_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned KEY_W  = 16
);
  logic              req0, req1;
  logic [1:0]        mode0, mode1;
  logic [DATA_W-1:0] din0, din1;
  logic [KEY_W-1:0]  kin0, kin1;

  logic              gnt0, gnt1;
  logic              done0, done1;
  logic              err0, err1;
  logic [DATA_W-1:0] dout;
  logic [KEY_W-1:0]  kout;
  logic              busy;

  logic              core_bgn;
  logic [1:0]        core_mode;
  logic [DATA_W-1:0] core_data;
  logic [KEY_W-1:0]  core_key;
  logic              core_out_data, core_out_key, core_fin;
  logic [DATA_W-1:0] core_result;

  modport master (
    output req0, req1, mode0, mode1, din0, din1, kin0, kin1,
    output core_out_data, core_out_key, core_fin, core_result,
    input  gnt0, gnt1, done0, done1, err0, err1, dout, kout, busy,
    input  core_bgn, core_mode, core_data, core_key
  );

  modport slave (
    input  req0, req1, mode0, mode1, din0, din1, kin0, kin1,
    input  core_out_data, core_out_key, core_fin, core_result,
    output gnt0, gnt1, done0, done1, err0, err1, dout, kout, busy,
    output core_bgn, core_mode, core_data, core_key
  );
endinterface

// File: rtl/crypto_job_arbiter.sv
// Round-robin scheduler sharing one crypto core between two requesters.
// Optional watchdog enabled by defining CRYPTO_ARB_TIMEOUT_EN.
module crypto_job_arbiter #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned KEY_W   = 16,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 rst,
  crypto_job_arbiter_if.slave  bus
);

  if (KEY_W > DATA_W || TIMEOUT == 0 || TIMEOUT > 63) begin : g_cfg_check
    $error("crypto_job_arbiter: KEY_W must not exceed DATA_W and TIMEOUT must be 1..63");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_RES,
    S_DELIVER,
`ifdef CRYPTO_ARB_TIMEOUT_EN
    S_TIMEOUT,
`endif
    S_REJECT
  } state_t;

  state_t            state_q;
  logic              owner_q;
  logic              last_q;   // port served most recently
  logic [1:0]        gnt_q, done_q, err_q;
  logic              busy_q, bgn_q;
  logic [1:0]        cmode_q;
  logic [DATA_W-1:0] cdata_q, dout_q;
  logic [KEY_W-1:0]  ckey_q, kout_q;

`ifdef CRYPTO_ARB_TIMEOUT_EN
  // Last WAIT_RES count before the limit; the count reaches TIMEOUT on this cycle.
  localparam logic [5:0] CntLast = 6'(TIMEOUT - 1);
  logic [5:0] cnt_q;
`endif

  logic              req_any, win_d, mode_ok;
  logic [1:0]        mode_d;
  logic [DATA_W-1:0] din_d;
  logic [KEY_W-1:0]  kin_d;

  always_comb begin
    req_any = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      win_d = ~last_q;
    end else begin
      win_d = bus.req1;
    end
    mode_d  = win_d ? bus.mode1 : bus.mode0;
    din_d   = win_d ? bus.din1  : bus.din0;
    kin_d   = win_d ? bus.kin1  : bus.kin0;
    mode_ok = (mode_d == 2'b01) || (mode_d == 2'b10);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      bgn_q   <= 1'b0;
      cmode_q <= '0;
      cdata_q <= '0;
      ckey_q  <= '0;
      dout_q  <= '0;
      kout_q  <= '0;
`ifdef CRYPTO_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      bgn_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_any) begin
            owner_q        <= win_d;
            last_q         <= win_d;
            busy_q         <= 1'b1;
            gnt_q[win_d]   <= 1'b1;
            if (mode_ok) begin
              state_q <= S_LAUNCH;
              bgn_q   <= 1'b1;
              cmode_q <= mode_d;
              cdata_q <= din_d;
              ckey_q  <= kin_d;
            end else begin
              state_q      <= S_REJECT;
              err_q[win_d] <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          state_q <= S_WAIT_RES;
`ifdef CRYPTO_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        S_WAIT_RES: begin
          if (bus.core_out_data) dout_q <= bus.core_result;
          if (bus.core_out_key)  kout_q <= bus.core_result[KEY_W-1:0];
          // core_fin takes priority over an expiring watchdog
          if (bus.core_fin) begin
            state_q         <= S_DELIVER;
            done_q[owner_q] <= 1'b1;
          end
`ifdef CRYPTO_ARB_TIMEOUT_EN
          else if (cnt_q == CntLast) begin
            state_q        <= S_TIMEOUT;
            err_q[owner_q] <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
`endif
        end
`ifdef CRYPTO_ARB_TIMEOUT_EN
        S_TIMEOUT,
`endif
        S_DELIVER, S_REJECT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cmode_q <= '0;
          cdata_q <= '0;
          ckey_q  <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt_q[0];
  assign bus.gnt1      = gnt_q[1];
  assign bus.done0     = done_q[0];
  assign bus.done1     = done_q[1];
  assign bus.err0      = err_q[0];
  assign bus.err1      = err_q[1];
  assign bus.busy      = busy_q;
  assign bus.dout      = dout_q;
  assign bus.kout      = kout_q;
  assign bus.core_bgn  = bgn_q;
  assign bus.core_mode = cmode_q;
  assign bus.core_data = cdata_q;
  assign bus.core_key  = ckey_q;

endmodule

// File: tb/tb_crypto_job_arbiter.sv
// Scoreboard bench for crypto_job_arbiter: driver pushes expected events, monitor pops them.
`timescale 1ns/1ps
module tb_crypto_job_arbiter;
  localparam int unsigned DW = 16;
  localparam int unsigned KW = 16;
  localparam int unsigned TO = 63;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  crypto_job_arbiter_if #(.DATA_W(DW), .KEY_W(KW)) bus ();

  crypto_job_arbiter #(.DATA_W(DW), .KEY_W(KW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  gnt, err, done;
    logic        bgn;
    logic [1:0]  cmode;
    logic [15:0] cdata, ckey, dout, kout;
  } exp_t;

  typedef struct {
    logic        d, k, f;
    logic [15:0] v;
  } beat_t;

  exp_t  sb_q[$];
  beat_t beat_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    last_srv;
  logic [15:0] m_dout, m_kout;
  exp_t  mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int c, input logic [1:0] g, input logic [1:0] e,
                              input logic [1:0] d, input logic b, input logic [1:0] cm,
                              input logic [15:0] cd, input logic [15:0] ck);
    exp_t x;
    x.cyc = c; x.gnt = g; x.err = e; x.done = d; x.bgn = b;
    x.cmode = cm; x.cdata = cd; x.ckey = ck; x.dout = m_dout; x.kout = m_kout;
    return x;
  endfunction

  // Monitor: every grant/done/error pulse must match the next expected event.
  always @(negedge clk) begin
    if (rst && ({bus.gnt0, bus.gnt1, bus.err0, bus.err1, bus.done0, bus.done1} != 6'd0)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_event", 64'({bus.gnt1, bus.gnt0, bus.err1, bus.err0, bus.done1, bus.done0}), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("event_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("gnt",        64'({bus.gnt1, bus.gnt0}),   64'(mon_e.gnt));
        check("err",        64'({bus.err1, bus.err0}),   64'(mon_e.err));
        check("done",       64'({bus.done1, bus.done0}), 64'(mon_e.done));
        check("core_bgn",   64'(bus.core_bgn),  64'(mon_e.bgn));
        check("core_mode",  64'(bus.core_mode), 64'(mon_e.cmode));
        check("core_data",  64'(bus.core_data), 64'(mon_e.cdata));
        check("core_key",   64'(bus.core_key),  64'(mon_e.ckey));
        check("dout",       64'(bus.dout),      64'(mon_e.dout));
        check("kout",       64'(bus.kout),      64'(mon_e.kout));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, 64'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1,
                                bus.busy, bus.core_bgn, bus.core_mode}), 64'd0);
    check({tag, "_core"}, 64'({bus.core_data, bus.core_key}), 64'd0);
    check({tag, "_result"}, 64'({bus.dout, bus.kout}), 64'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_idle", 64'(bus.busy), 64'd0);
  endtask

  function automatic logic [1:0] rmode();
    if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
    return ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic run_job(input logic r0, input logic r1, input logic [1:0] m0, input logic [1:0] m1,
                         input logic [15:0] d0, input logic [15:0] k0,
                         input logic [15:0] d1, input logic [15:0] k1,
                         input bit hold, input bit hang);
    logic        win;
    logic [1:0]  wm;
    logic [15:0] wd, wk;
    bit          ok;
    int          lc, n;
    beat_t       b;
    wait_idle();
    // Tie goes to the port that was not served last; otherwise the sole requester.
    win = (r0 && r1) ? (last_srv == 0) : r1;
    last_srv = win ? 1 : 0;
    wm = win ? m1 : m0;
    wd = win ? d1 : d0;
    wk = win ? k1 : k0;
    ok = (wm == 2'b01) || (wm == 2'b10);
    lc = cyc + 1;
    if (ok) sb_q.push_back(mk(lc, 2'b01 << win, 2'b00, 2'b00, 1'b1, wm, wd, wk));
    else    sb_q.push_back(mk(lc, 2'b01 << win, 2'b01 << win, 2'b00, 1'b0, 2'b00, 16'h0, 16'h0));
    bus.req0 = r0; bus.req1 = r1;
    bus.mode0 = m0; bus.mode1 = m1;
    bus.din0 = d0; bus.kin0 = k0; bus.din1 = d1; bus.kin1 = k1;
    @(negedge clk);
    if (!hold) begin
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.mode0 = 2'($urandom); bus.mode1 = 2'($urandom);
      bus.din0 = 16'($urandom); bus.din1 = 16'($urandom);
      bus.kin0 = 16'($urandom); bus.kin1 = 16'($urandom);
    end
    bus.core_out_data = 1'b1;
    bus.core_out_key  = 1'b1;
    bus.core_result   = 16'($urandom);
    if (!ok || hang) begin
`ifdef CRYPTO_ARB_TIMEOUT_EN
      if (hang) sb_q.push_back(mk(lc + 64, 2'b00, 2'b01 << win, 2'b00, 1'b0, wm, wd, wk));
`endif
      @(negedge clk);
      bus.core_out_data = 1'b0;
      bus.core_out_key  = 1'b0;
      return;
    end
    if (beat_q.size() == 0) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b.d = 1'($urandom_range(0, 1));
        b.k = 1'($urandom_range(0, 1));
        b.f = (i == n - 1);
        b.v = 16'($urandom);
        beat_q.push_back(b);
      end
    end
    while (beat_q.size() != 0) begin
      b = beat_q.pop_front();
      @(negedge clk);
      bus.core_out_data = b.d;
      bus.core_out_key  = b.k;
      bus.core_fin      = b.f;
      bus.core_result   = b.v;
      if (b.d) m_dout = b.v;
      if (b.k) m_kout = b.v;
      if (b.f) sb_q.push_back(mk(cyc + 1, 2'b00, 2'b00, 2'b01 << win, 1'b0, wm, wd, wk));
    end
    @(negedge clk);
    bus.core_out_data = 1'b1;
    bus.core_out_key  = 1'b1;
    bus.core_fin      = 1'b1;
    bus.core_result   = 16'($urandom);
    @(negedge clk);
    bus.core_out_data = 1'b0;
    bus.core_out_key  = 1'b0;
    bus.core_fin      = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int    r, lows;
    beat_t b;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.mode0 = 2'b00; bus.mode1 = 2'b00;
    bus.din0 = '0; bus.din1 = '0; bus.kin0 = '0; bus.kin1 = '0;
    bus.core_out_data = 1'b0; bus.core_out_key = 1'b0; bus.core_fin = 1'b0;
    bus.core_result = '0;
    last_srv = 1; m_dout = '0; m_kout = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Both ports held high for three jobs: order 0,1,0.
    run_job(1'b1, 1'b1, 2'b01, 2'b10, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1, 1'b0);
    run_job(1'b1, 1'b1, 2'b01, 2'b10, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1, 1'b0);
    run_job(1'b1, 1'b1, 2'b01, 2'b10, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 1'b0);

    // Encrypt on port 0 with a scripted core.
    b.d = 1'b1; b.k = 1'b0; b.f = 1'b0; b.v = 16'h3C3C; beat_q.push_back(b);
    b.d = 1'b0; b.k = 1'b1; b.f = 1'b0; b.v = 16'h00FF; beat_q.push_back(b);
    b.d = 1'b0; b.k = 1'b0; b.f = 1'b1; b.v = 16'hDEAD; beat_q.push_back(b);
    run_job(1'b1, 1'b0, 2'b01, 2'b00, 16'hA5A5, 16'h1234, 16'h0, 16'h0, 1'b0, 1'b0);

    // Invalid mode on port 1.
    run_job(1'b0, 1'b1, 2'b00, 2'b11, 16'h0, 16'h0, 16'hBEEF, 16'hCAFE, 1'b0, 1'b0);

    for (int j = 0; j < 40; j++) begin
      r = $urandom_range(1, 3);
      run_job(r[0], r[1], rmode(), rmode(), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 1'b0, 1'b0);
    end

`ifdef CRYPTO_ARB_TIMEOUT_EN
    run_job(1'b1, 1'b0, 2'b01, 2'b00, 16'h0F0F, 16'hF0F0, 16'h0, 16'h0, 1'b0, 1'b1);
    repeat (70) @(negedge clk);
    // core_fin in the cycle the count reaches TIMEOUT
    for (int i = 0; i < 62; i++) begin
      b.d = 1'b0; b.k = 1'b0; b.f = 1'b0; b.v = 16'h0;
      beat_q.push_back(b);
    end
    b.d = 1'b1; b.k = 1'b1; b.f = 1'b1; b.v = 16'h5A5A; beat_q.push_back(b);
    run_job(1'b0, 1'b1, 2'b00, 2'b10, 16'h0, 16'h0, 16'h7777, 16'h8888, 1'b0, 1'b0);
`endif

    // Core never finishes: arbiter stays busy, then reset abandons the job.
    run_job(1'b1, 1'b0, 2'b10, 2'b00, 16'h1357, 16'h2468, 16'h0, 16'h0, 1'b0, 1'b1);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.busy) lows++;
    end
    check("busy_while_hung", 64'(lows), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midjob_reset");
    sb_q.delete();
    last_srv = 1; m_dout = '0; m_kout = '0;
    rst = 1'b1;
    @(negedge clk);

    run_job(1'b1, 1'b1, 2'b10, 2'b01, 16'h4321, 16'h8765, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crypto_job_arbiter.md
# crypto_job_arbiter

Round-robin job scheduler that shares the single cryptographic core between two requesters (port 0, port 1). It captures a requester's operands, launches the core with a one-cycle `core_bgn` pulse, and holds mode, data and key stable for the whole run. It collects the core's serialized data and key results, then returns them to the owning port with a `done` pulse. It sits between the processor-side requesters and the crypto control unit/datapath.

## Interface
- `DATA_W`, default 16: data block width.
- `KEY_W`, default 16: key width; must be ≤ `DATA_W` (result bus is shared).
- `TIMEOUT`, default 63: watchdog limit in cycles; 6-bit counter.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset is synchronous and active-low.
- `req0`/`req1` in 1: job request, level-sensitive.
- `mode0`/`mode1` in 2: 01 = encrypt, 10 = decrypt, 00 and 11 are invalid.
- `din0`/`din1` in `DATA_W`: plaintext or ciphertext.
- `kin0`/`kin1` in `KEY_W`: key.
- `gnt0`/`gnt1` out 1: one-cycle pulse; operands have been captured.
- `done0`/`done1` out 1: one-cycle pulse; `dout`/`kout` valid.
- `err0`/`err1` out 1: one-cycle pulse for invalid mode or timeout.
- `dout` out `DATA_W`, `kout` out `KEY_W`: shared result registers.
- `busy` out 1: high in every state except IDLE.
- `core_bgn` out 1, `core_mode` out 2, `core_data` out `DATA_W`, `core_key` out `KEY_W`: core launch signals.
- `core_out_data`/`core_out_key`/`core_fin` in 1: core result strobes.
- `core_result` in `DATA_W`: core output bus.

## Operation
- **States:** IDLE, LAUNCH, WAIT_RES, DELIVER, REJECT, and TIMEOUT (TIMEOUT exists only with the macro).
- **IDLE**
  - Samples `req0`/`req1`.
  - Winner selection: a single request wins. If both request, the port not served last wins. After reset, port 0 wins the first tie.
  - On the edge that leaves IDLE: capture the winner's mode/din/kin, record the owner, and update the last-served pointer.
  - Valid mode → LAUNCH.
  - Invalid mode → REJECT. The core is not launched, and the pointer is still updated.
- **LAUNCH:** `gnt<owner>`=1 and `core_bgn`=1 for exactly this cycle, then → WAIT_RES.
- **Core drive:** `core_mode`/`core_data`/`core_key` are driven from the captured registers. They are constant from LAUNCH through DELIVER, and are 0 in IDLE.
- **WAIT_RES**
  - `core_out_data`=1 loads `dout` ← `core_result`.
  - `core_out_key`=1 loads `kout` ← `core_result[KEY_W-1:0]`.
  - `core_fin`=1 → DELIVER. Strobes arriving in the same cycle as `core_fin` are still captured.
- **DELIVER:** `done<owner>`=1 for one cycle, then → IDLE.
- **Result hold:** `dout`/`kout` hold their values until overwritten by a later job's strobes.
- **REJECT:** `gnt<owner>`=1 and `err<owner>`=1 in the same single cycle, then → IDLE. `dout`/`kout` are unchanged.
- **Requester protocol**
  - Keep mode/din/kin stable while `req` is high and before `gnt`.
  - Drop `req` after `gnt`. A `req` still high when the arbiter returns to IDLE is treated as a new job.
- **Core strobes in the wrong state:** `core_*` strobes outside WAIT_RES are ignored.
- **Reset**
  - All outputs 0, `dout`/`kout` 0, state IDLE, pointer = "port 1 last".
  - Reset mid-job abandons the job with no `done`/`err`. The core must be reset by the same `rst`.

## Timing
- A request seen in IDLE at cycle N gives `gnt` and `core_bgn` in cycle N+1; WAIT_RES starts at N+2.
- `core_fin` at cycle M gives `done` in cycle M+1; IDLE at M+2. The earliest next grant is M+3.
- Invalid mode seen at cycle N gives `gnt`+`err` at N+1; IDLE at N+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `CRYPTO_ARB_TIMEOUT_EN`.
- **Defined**
  - A 6-bit counter clears on LAUNCH and increments each WAIT_RES cycle.
  - When the count reaches `TIMEOUT` without `core_fin` → TIMEOUT state: `err<owner>`=1 for one cycle, no `done`, then → IDLE.
  - If `core_fin` arrives in the same cycle the count reaches `TIMEOUT`, `core_fin` wins and the job goes to DELIVER.
- **Undefined:** no counter and no TIMEOUT state; WAIT_RES waits indefinitely, and `err` arises only from invalid mode.

## Test plan
- Encrypt job on port 0:
  - Stimulus: `req0`=1, `mode0`=01, `din0`=16'hA5A5, `kin0`=16'h1234. The core model strobes `core_out_data` with 16'h3C3C, `core_out_key` with 16'h00FF, then `core_fin`.
  - Required: `gnt0`+`core_bgn` one cycle later; `core_mode`=01 held until DELIVER; `done0`=1 one cycle after `core_fin` with `dout`=16'h3C3C and `kout`=16'h00FF.
- Fairness:
  - Stimulus: `req0` and `req1` held high for three consecutive jobs.
  - Required: grant order 0,1,0; `done1` never pulses for a port-0 job.
- Invalid mode:
  - Stimulus: `req1`=1, `mode1`=11.
  - Required: `gnt1`=`err1`=1 in the same cycle; `core_bgn` stays 0; `dout` is unchanged.
- Timeout (macro defined):
  - Stimulus: `TIMEOUT`=63, the core never asserts `core_fin`.
  - Required: `err0` exactly 64 cycles after LAUNCH; no `done0`.
  - With the macro undefined, `busy` stays 1 indefinitely.
- Reset mid-job:
  - Stimulus: `rst`=0 during WAIT_RES.
  - Required: next cycle all outputs 0, `busy`=0; a simultaneous-request tie after reset is granted to port 0.
- Boundary (macro defined):
  - Stimulus: `core_fin` arrives in the same cycle the count reaches `TIMEOUT`.
  - Required: `done` pulses and `err` stays 0.
